// File: rtl/readout_pulse_gen.sv
// rtl/readout_pulse_gen.sv - triggered I/Q readout tone generator, five samples per clock
module readout_pulse_gen #(
    parameter int AMP_W = 16,
    parameter int LEN_W = 11,
    parameter int DLY_W = 10
) (
    input  logic                    clk100,
    input  logic                    reset_n,
    input  logic                    trigger,
    input  logic [4:0]              mod_freq,
    input  logic [LEN_W-1:0]        pulse_length,
    input  logic [DLY_W-1:0]        delay_time,
    input  logic signed [AMP_W-1:0] amplitude,
    output logic signed [AMP_W-1:0] data0_out_0,
    output logic signed [AMP_W-1:0] data0_out_1,
    output logic signed [AMP_W-1:0] data0_out_2,
    output logic signed [AMP_W-1:0] data0_out_3,
    output logic signed [AMP_W-1:0] data0_out_4,
    output logic signed [AMP_W-1:0] data1_out_0,
    output logic signed [AMP_W-1:0] data1_out_1,
    output logic signed [AMP_W-1:0] data1_out_2,
    output logic signed [AMP_W-1:0] data1_out_3,
    output logic signed [AMP_W-1:0] data1_out_4,
    output logic                    pulse_active,
    output logic                    marker,
    output logic                    busy,
    output logic                    done
);
    localparam int CNT_W = (LEN_W > DLY_W) ? LEN_W : DLY_W;

    typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;
    state_t state, state_n;

    logic                    trig_q;
    logic [4:0]              mf_lat;
    logic [LEN_W-1:0]        len_lat;
    logic [DLY_W-1:0]        dly_lat;
    logic signed [AMP_W-1:0] amp_lat;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [5:0]              base, base_step;
    logic                    accept, end_tok;
    logic                    v1, f1, e1, v2, mk_q, e2, done_q;
    logic [5:0]              ph_w  [5];
    logic [7:0]              sin_m [5];
    logic signed [15:0]      cos_w [5];
    logic signed [15:0]      sin_w [5];
    logic signed [15:0]      lut_i [5];
    logic signed [15:0]      lut_q [5];
    logic signed [31:0]      prod_i [5];
    logic signed [31:0]      prod_q [5];
    logic signed [AMP_W-1:0] out_i [5];
    logic signed [AMP_W-1:0] out_q [5];

    function automatic logic [5:0] mod50(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int j = 0; j < 3; j++) begin
            if (r >= 8'd50) r = r - 8'd50;
        end
        return r[5:0];
    endfunction

    // round(32767*cos(m*3.6 deg)) for m = 0..25; both 50-point tables fold onto this.
    function automatic logic [15:0] qtab(input logic [4:0] m);
        case (m)
            5'd0:  return 16'd32767;
            5'd1:  return 16'd32702;
            5'd2:  return 16'd32509;
            5'd3:  return 16'd32187;
            5'd4:  return 16'd31738;
            5'd5:  return 16'd31163;
            5'd6:  return 16'd30466;
            5'd7:  return 16'd29648;
            5'd8:  return 16'd28714;
            5'd9:  return 16'd27666;
            5'd10: return 16'd26509;
            5'd11: return 16'd25247;
            5'd12: return 16'd23886;
            5'd13: return 16'd22431;
            5'd14: return 16'd20886;
            5'd15: return 16'd19260;
            5'd16: return 16'd17557;
            5'd17: return 16'd15786;
            5'd18: return 16'd13952;
            5'd19: return 16'd12062;
            5'd20: return 16'd10126;
            5'd21: return 16'd8149;
            5'd22: return 16'd6140;
            5'd23: return 16'd4107;
            5'd24: return 16'd2057;
            default: return 16'd0;
        endcase
    endfunction

    // Cosine on a 100-point (3.6 deg) grid; cos table uses m = 2p, sin uses m = 2p + 75.
    function automatic logic signed [15:0] wave(input logic [6:0] m);
        logic [4:0] i;
        logic       neg;
        if (m <= 7'd25) begin
            i = m[4:0];             neg = 1'b0;
        end else if (m <= 7'd50) begin
            i = 5'(7'd50 - m);      neg = 1'b1;
        end else if (m <= 7'd75) begin
            i = 5'(m - 7'd50);      neg = 1'b1;
        end else begin
            i = 5'(7'd100 - m);     neg = 1'b0;
        end
        return neg ? -$signed(qtab(i)) : $signed(qtab(i));
    endfunction

    assign cnt_next = cnt + CNT_W'(1);
    assign busy     = (state != IDLE) || e1 || e2;

    always_comb begin
        base_step = mod50(8'(mf_lat) * 8'd5);
        for (int k = 0; k < 5; k++) begin
            ph_w[k]  = mod50(8'(base) + 8'(mf_lat) * 8'(k));
            sin_m[k] = {1'b0, ph_w[k], 1'b0} + 8'd75;
            if (sin_m[k] >= 8'd100) sin_m[k] = sin_m[k] - 8'd100;
            cos_w[k]  = wave({ph_w[k], 1'b0});
            sin_w[k]  = wave(sin_m[k][6:0]);
            prod_i[k] = 32'(amp_lat) * 32'(lut_i[k]);
            prod_q[k] = 32'(amp_lat) * 32'(lut_q[k]);
        end
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // done_q blocks acceptance so the earliest retrigger is the cycle after done.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        end_tok = 1'b0;
        case (state)
            IDLE: begin
                if (trigger && !trig_q && !busy && !done_q) begin
                    state_n = DELAY;
                    accept  = 1'b1;
                end
            end
            DELAY: begin
                if (cnt == CNT_W'(dly_lat)) begin
                    if (len_lat == '0) begin
                        state_n = IDLE;
                        end_tok = 1'b1;
                    end else begin
                        state_n = PULSE;
                    end
                end
            end
            PULSE: begin
                if (cnt_next == CNT_W'(len_lat)) begin
                    state_n = IDLE;
                    end_tok = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // end_tok rides a three-stage delay so done lands after the last output cycle,
    // including the zero-length case where no samples flow.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            trig_q  <= 1'b0;
            mf_lat  <= '0;
            len_lat <= '0;
            dly_lat <= '0;
            amp_lat <= '0;
            cnt     <= '0;
            base    <= '0;
            v1      <= 1'b0;
            f1      <= 1'b0;
            e1      <= 1'b0;
            v2      <= 1'b0;
            mk_q    <= 1'b0;
            e2      <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                lut_i[k] <= '0;
                lut_q[k] <= '0;
                out_i[k] <= '0;
                out_q[k] <= '0;
            end
        end else begin
            trig_q <= trigger;
            if (accept) begin
                mf_lat  <= mod_freq;
                len_lat <= pulse_length;
                dly_lat <= delay_time;
                amp_lat <= amplitude;
                cnt     <= '0;
                base    <= '0;
            end else if (state == DELAY) begin
                cnt <= (state_n == DELAY) ? cnt_next : '0;
            end else if (state == PULSE) begin
                cnt  <= cnt_next;
                base <= mod50(8'(base) + 8'(base_step));
            end
            v1   <= (state == PULSE);
            f1   <= (state == PULSE) && (cnt == '0);
            e1   <= end_tok;
            v2   <= v1;
            mk_q <= f1;
            e2   <= e1;
            done_q <= e2;
            for (int k = 0; k < 5; k++) begin
                lut_i[k] <= cos_w[k];
                lut_q[k] <= sin_w[k];
                out_i[k] <= v1 ? AMP_W'(prod_i[k] >>> 15) : '0;
                out_q[k] <= v1 ? AMP_W'(prod_q[k] >>> 15) : '0;
            end
        end
    end

    assign pulse_active = v2;
    assign marker       = mk_q;
    assign done         = done_q;
    assign data0_out_0  = out_i[0];
    assign data0_out_1  = out_i[1];
    assign data0_out_2  = out_i[2];
    assign data0_out_3  = out_i[3];
    assign data0_out_4  = out_i[4];
    assign data1_out_0  = out_q[0];
    assign data1_out_1  = out_q[1];
    assign data1_out_2  = out_q[2];
    assign data1_out_3  = out_q[3];
    assign data1_out_4  = out_q[4];
endmodule

// File: tb/tb_readout_pulse_gen.sv
// tb/tb_readout_pulse_gen.sv - directed self-checking bench for readout_pulse_gen
module tb_readout_pulse_gen;
    localparam int AMP_W = 16;
    localparam int LEN_W = 11;
    localparam int DLY_W = 10;

    logic                    clk100 = 1'b0;
    logic                    reset_n;
    logic                    trigger;
    logic [4:0]              mod_freq;
    logic [LEN_W-1:0]        pulse_length;
    logic [DLY_W-1:0]        delay_time;
    logic signed [AMP_W-1:0] amplitude;
    logic signed [AMP_W-1:0] d0 [5];
    logic signed [AMP_W-1:0] d1 [5];
    logic                    pulse_active, marker, busy, done;

    int checks = 0;
    int errors = 0;
    int cos_t [50];
    int sin_t [50];
    int obs_i [16][5];
    int obs_q [16][5];
    int n_marker, n_done;
    int ph7 [15] = '{0, 7, 14, 21, 28, 35, 42, 49, 6, 13, 20, 27, 34, 41, 48};
    int hand_i25 [5] = '{16383, -16384, 16383, -16384, 16383};

    always #5 clk100 = ~clk100;

    readout_pulse_gen #(.AMP_W(AMP_W), .LEN_W(LEN_W), .DLY_W(DLY_W)) dut (
        .clk100(clk100), .reset_n(reset_n), .trigger(trigger), .mod_freq(mod_freq),
        .pulse_length(pulse_length), .delay_time(delay_time), .amplitude(amplitude),
        .data0_out_0(d0[0]), .data0_out_1(d0[1]), .data0_out_2(d0[2]),
        .data0_out_3(d0[3]), .data0_out_4(d0[4]),
        .data1_out_0(d1[0]), .data1_out_1(d1[1]), .data1_out_2(d1[2]),
        .data1_out_3(d1[3]), .data1_out_4(d1[4]),
        .pulse_active(pulse_active), .marker(marker), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk100);
        #2;
    endtask

    function automatic int exp_samp(input int amp, input int tv);
        int p;
        logic signed [15:0] t;
        p = amp * tv;
        t = 16'(p >>> 15);
        return int'(t);
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, " pulse_active"}, pulse_active, 0);
        chk({tag, " marker"}, marker, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("%s i%0d", tag, k), d0[k], 0);
            chk($sformatf("%s q%0d", tag, k), d1[k], 0);
        end
    endtask

    // Trigger a pulse and check cycles T+1..T+stop (stop=0: through the done cycle).
    task automatic scan(input int mf, input int amp, input int len, input int dly,
                        input int retrig, input int stop);
        int ncyc, n, ph, act;
        ncyc = (stop > 0) ? stop : 4 + dly + len;
        step();
        mod_freq     = 5'(mf);
        amplitude    = 16'(amp);
        pulse_length = LEN_W'(len);
        delay_time   = DLY_W'(dly);
        trigger      = 1'b1;
        n_marker = 0;
        n_done   = 0;
        for (int c = 1; c <= ncyc; c++) begin
            step();
            trigger = (c == retrig);
            if (c == 1) begin
                mod_freq     = 5'(mf + 13);
                amplitude    = -16'sd1234;
                pulse_length = 11'd5;
                delay_time   = 10'd3;
            end
            act = int'(len > 0 && c >= 4 + dly && c < 4 + dly + len);
            chk($sformatf("pulse_active c%0d", c), pulse_active, act);
            chk($sformatf("marker c%0d", c), marker, int'(len > 0 && c == 4 + dly));
            chk($sformatf("done c%0d", c), done, int'(c == 4 + dly + len));
            chk($sformatf("busy c%0d", c), busy, int'(c < 4 + dly + len));
            n_marker += int'(marker);
            n_done   += int'(done);
            n = c - 4 - dly;
            for (int k = 0; k < 5; k++) begin
                if (act != 0) begin
                    ph = (mf * (5 * n + k)) % 50;
                    chk($sformatf("i c%0d k%0d", c, k), d0[k], exp_samp(amp, cos_t[ph]));
                    chk($sformatf("q c%0d k%0d", c, k), d1[k], exp_samp(amp, sin_t[ph]));
                    if (n < 16) begin
                        obs_i[n][k] = int'(d0[k]);
                        obs_q[n][k] = int'(d1[k]);
                    end
                end else begin
                    chk($sformatf("i idle c%0d k%0d", c, k), d0[k], 0);
                    chk($sformatf("q idle c%0d k%0d", c, k), d1[k], 0);
                end
            end
        end
    endtask

    initial begin
        for (int p = 0; p < 50; p++) begin
            cos_t[p] = int'($floor(32767.0 * $cos(6.283185307179586 * p / 50.0) + 0.5));
            sin_t[p] = int'($floor(32767.0 * $sin(6.283185307179586 * p / 50.0) + 0.5));
        end
        reset_n      = 1'b0;
        trigger      = 1'b0;
        mod_freq     = '0;
        pulse_length = '0;
        delay_time   = '0;
        amplitude    = '0;
        step();
        step();
        chk_quiet("reset");
        reset_n = 1'b1;
        step();

        // mod_freq 0: flat I, zero Q
        scan(0, 16384, 3, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("t1 i n%0d k%0d", n, k), obs_i[n][k], 16383);
                chk($sformatf("t1 q n%0d k%0d", n, k), obs_q[n][k], 0);
            end
        end
        chk("t1 markers", n_marker, 1);
        chk("t1 dones", n_done, 1);

        // mod_freq 25: alternating sign, retriggered in the cycle after done
        scan(25, 16384, 2, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2 i k%0d", k), obs_i[0][k], hand_i25[k]);
            chk($sformatf("t2 q k%0d", k), obs_q[0][k], 0);
        end

        // mod_freq 7: phase wrap across cycles
        scan(7, 20000, 3, 0, 0, 0);
        for (int j = 0; j < 15; j++) begin
            chk($sformatf("t3 i s%0d", j), obs_i[j / 5][j % 5], exp_samp(20000, cos_t[ph7[j]]));
            chk($sformatf("t3 q s%0d", j), obs_q[j / 5][j % 5], exp_samp(20000, sin_t[ph7[j]]));
        end

        // long delay, second edge while busy is ignored
        scan(3, -12000, 4, 10, 6, 0);
        chk("t4 markers", n_marker, 1);
        chk("t4 dones", n_done, 1);

        // zero length: done only
        scan(9, 5000, 0, 2, 0, 0);
        chk("t5 markers", n_marker, 0);
        chk("t5 dones", n_done, 1);
        step();
        chk("t5 busy after", busy, 0);

        // asynchronous reset during output cycle 2 of a 10-cycle pulse
        scan(11, 30000, 10, 0, 0, 6);
        #1;
        reset_n = 1'b0;
        #1;
        chk_quiet("abort");
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            chk($sformatf("post abort done c%0d", c), done, 0);
            chk($sformatf("post abort busy c%0d", c), busy, 0);
            chk($sformatf("post abort active c%0d", c), pulse_active, 0);
        end
        scan(11, 30000, 10, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t6 i k%0d", k), obs_i[0][k], exp_samp(30000, cos_t[11 * k]));
            chk($sformatf("t6 q k%0d", k), obs_q[0][k], exp_samp(30000, sin_t[11 * k]));
        end
        chk("t6 markers", n_marker, 1);
        chk("t6 dones", n_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/readout_pulse_gen.md
# readout_pulse_gen

Transmit-side counterpart of the I/Q demodulation chain: on a trigger, synthesises the qubit readout tone as 5 samples per clock on separate I and Q DAC buses. The output uses the same 1/50-cycle phase grid and sample ordering that the demodulator counter-rotates against, so a looped-back pulse demodulates to a constant vector. It also emits a one-cycle marker aligned to the first output sample, which the readout trigger/timing path uses.

## Interface
- AMP_W, 16: amplitude and DAC sample width (signed).
- LEN_W, 11: pulse length counter width (clock cycles).
- DLY_W, 10: start-delay counter width (clock cycles).
- clk100  in  1: system clock. All state is on the rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- trigger  in  1: level input. A rising edge, detected against the registered previous value, starts a pulse when the block is idle.
- mod_freq  in  5: phase step per sample, in units of 1/50 cycle (0..31).
- pulse_length  in  LEN_W: number of output cycles (5 samples each).
- delay_time  in  DLY_W: cycles between the trigger edge and the start of the pulse.
- amplitude  in  AMP_W signed: peak amplitude.
- data0_out_0..data0_out_4  out  AMP_W signed each: I samples. _0 is the earliest sample in the cycle.
- data1_out_0..data1_out_4  out  AMP_W signed each: Q samples, same ordering.
- pulse_active  out  1: high while the data outputs carry pulse samples.
- marker  out  1: one-cycle strobe on the first pulse_active cycle.
- busy  out  1: high from the cycle after the trigger edge until done.
- done  out  1: one-cycle strobe on the cycle after the last pulse_active cycle.

## Operation
- FSM states: IDLE, DELAY, PULSE.
  - IDLE → DELAY on a trigger rising edge. On that edge the block latches mod_freq, pulse_length, delay_time and amplitude. Input changes afterwards have no effect until the next pulse.
  - DELAY counts delay_time cycles. When delay_time = 0, it lasts exactly one cycle.
  - DELAY → PULSE when the count expires. If pulse_length = 0, DELAY → IDLE instead: no pulse_active, no marker, but done still strobes at the point the pulse would have ended.
  - PULSE lasts pulse_length cycles, then → IDLE.
- Trigger edges while busy are ignored; they are not queued.
- Phase, for sample k (0..4) of pulse cycle n: ph = (mod_freq·(5n+k)) mod 50.
  - Implemented as a per-cycle base b_n = (b_{n-1} + (5·mod_freq mod 50)) mod 50, with b_0 = 0.
  - Per-sample offset: ph_k = (b_n + mod_freq·k) mod 50, reduced by at most 3 conditional subtractions of 50.
- LUT: 50-entry cos and sin tables, each entry round(32767·cos(2πp/50)) and round(32767·sin(2πp/50)).
- Output arithmetic:
  - I = (amplitude·cos[ph]) >>> 15.
  - Q = (amplitude·sin[ph]) >>> 15.
  - 32-bit signed product, arithmetic shift (floor), then truncate to AMP_W.
- Outside pulse_active, all data outputs are 0.
- Reset, asynchronous and possible mid-pulse: FSM → IDLE, counters and phase → 0. All outputs read 0 immediately, including pulse_active, marker, busy and done. No done strobe is produced for an aborted pulse.

## Timing
- Trigger edge registered at edge T: busy = 1 from T+1.
- PULSE occupies T+2+delay_time … T+1+delay_time+pulse_length.
- The data path has two pipeline stages (registered LUT read, registered multiply). Consequently:
  - pulse_active and the data outputs are valid from T+4+delay_time for pulse_length cycles.
  - marker coincides with the first of those cycles.
  - done is high for one cycle immediately after the last valid cycle, and busy falls in that same cycle.
- The earliest accepted retrigger is a rising edge registered in the cycle after done.
- Throughput: 5 samples per clk100 cycle with no bubbles inside a pulse.

## Test plan
- mod_freq = 0, amplitude = 16384, pulse_length = 3, delay_time = 0, trigger edge at T:
  - all I = 16383, all Q = 0 during T+4..T+6;
  - marker at T+4, done at T+7, outputs 0 elsewhere.
- mod_freq = 25, amplitude = 16384:
  - phases alternate 0, 25, 0, 25, 0;
  - I = 16383, −16384, 16383, −16384, 16383;
  - Q = 0 on every sample.
- mod_freq = 7, pulse_length = 3: phase wrap-around.
  - Cycle 0 phases: 0, 7, 14, 21, 28.
  - Cycle 1 phases: 35, 42, 49, 6, 13.
  - Cycle 2 phases: 20, 27, 34, 41, 48.
  - Output must match the LUT-derived I/Q values exactly.
- delay_time = 10, pulse_length = 4, with a second trigger edge at T+6:
  - first valid output at T+14, four cycles long;
  - second edge ignored: exactly one marker and one done.
- pulse_length = 0: no pulse_active, no marker; done strobes once and busy returns low.
- reset_n pulsed low during cycle 2 of a 10-cycle pulse:
  - all outputs 0 immediately, no done strobe;
  - the next trigger produces a full, correctly phased pulse starting at phase 0.
